// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key event path.
//   PS2_EXTEND / PS2_BREAK / PS2_BAT_OK : protocol prefix and self-test bytes
//   parse_state_t                       : parser position inside a scan-code sequence
//   idx_width / evt_width               : key index width and event word width
// Event word layout, MSB first: {rep, rel, idx}.
package ps2_pkg;

    localparam logic [7:0] PS2_EXTEND = 8'hE0;
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } parse_state_t;

    function automatic int unsigned idx_width(input int unsigned num_keys);
        return (num_keys <= 1) ? 1 : $clog2(num_keys);
    endfunction

    function automatic int unsigned evt_width(input int unsigned iw);
        return iw + 2;
    endfunction

endpackage

// File: rtl/sync_event_fifo.sv
// Synchronous first-word fall-through FIFO for key events.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data; accepted when not full, or when full with a pop this cycle
//   push_data  : word to enqueue
//   pop        : discard the head word (ignored when empty)
//   head       : current head word, valid while !empty
//   count      : number of stored words
//   full/empty : occupancy flags
module sync_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 key event queue: parses E0/F0 prefixed scan codes, tracks a per-key
// down bitmap for a small key table, generates auto-repeat for the most
// recently pressed key, and queues press/release/repeat events.
//   clk, rst          : clock, synchronous active-high reset
//   byte_in/byte_valid: received PS/2 byte and its one-cycle strobe
//   evt_ready         : consumer takes the head event
//   evt_valid/evt_idx/evt_release/evt_repeat : head event
//   key_down          : current down bitmap
//   fifo_count        : queued events
//   overflow          : sticky, a press/release was dropped on a full queue
//   clear_overflow    : clears overflow (a coincident set wins)
module ps2_key_event_queue
    import ps2_pkg::*;
#(
    parameter int unsigned           NUM_KEYS     = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES    = {9'h172, 9'h175, 9'h029, 9'h05A},
    parameter int unsigned           DEPTH        = 8,
    parameter int unsigned           REPEAT_EN    = 1,
    parameter int unsigned           REPEAT_DELAY = 50_000_000,
    parameter int unsigned           REPEAT_RATE  = 10_000_000,
    localparam int unsigned          IDX_W        = idx_width(NUM_KEYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    input  logic                    evt_ready,
    output logic                    evt_valid,
    output logic [IDX_W-1:0]        evt_idx,
    output logic                    evt_release,
    output logic                    evt_repeat,
    output logic [NUM_KEYS-1:0]     key_down,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    input  logic                    clear_overflow
);

    localparam int unsigned EVT_W = evt_width(IDX_W);

    parse_state_t     state;
    parse_state_t     state_next;
    logic             resolve;
    logic             res_ext;
    logic             res_break;
    logic             bat_reset;
    logic [8:0]       code;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;

    logic             rpt_valid;
    logic [IDX_W-1:0] rpt_idx;
    logic             rpt_first;
    logic             rpt_pending;
    logic [31:0]      rpt_cnt;
    logic [31:0]      rpt_limit;

    logic             do_press;
    logic             do_release;
    logic             par_push;
    logic             rep_push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EVT_W-1:0] push_data;
    logic [EVT_W-1:0] head;

    always_comb begin
        state_next = state;
        resolve    = 1'b0;
        res_ext    = 1'b0;
        res_break  = 1'b0;
        bat_reset  = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (byte_in == PS2_EXTEND)      state_next = EXT;
                    else if (byte_in == PS2_BREAK)  state_next = BRK;
                    else if (byte_in == PS2_BAT_OK) bat_reset  = 1'b1;
                    else                            resolve    = 1'b1;
                end
                EXT: begin
                    if (byte_in == PS2_BREAK) begin
                        state_next = EXT_BRK;
                    end else begin
                        resolve = 1'b1;
                        res_ext = 1'b1;
                    end
                end
                BRK: begin
                    resolve   = 1'b1;
                    res_break = 1'b1;
                end
                EXT_BRK: begin
                    resolve   = 1'b1;
                    res_ext   = 1'b1;
                    res_break = 1'b1;
                end
            endcase
            if (resolve) state_next = IDLE;
        end
    end

    assign code = {res_ext, byte_in};

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (KEY_CODES[(i-1)*9 +: 9] == code) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i - 1);
            end
        end
    end

    assign do_press   = resolve && hit && !res_break && !key_down[hit_idx];
    assign do_release = resolve && hit &&  res_break &&  key_down[hit_idx];
    assign par_push   = do_press || do_release;
    assign rep_push   = rpt_pending && !par_push;
    assign pop        = evt_valid && evt_ready;
    assign push_data  = par_push ? {1'b0, do_release, hit_idx} : {1'b1, 1'b0, rpt_idx};
    assign rpt_limit  = rpt_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            key_down    <= '0;
            rpt_valid   <= 1'b0;
            rpt_idx     <= '0;
            rpt_first   <= 1'b0;
            rpt_pending <= 1'b0;
            rpt_cnt     <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= state_next;

            // Timer raise outranks consuming the pending repeat; parser
            // updates below override both when the target changes.
            if (rep_push) rpt_pending <= 1'b0;
            if (rpt_valid && REPEAT_EN != 0) begin
                if (rpt_cnt == rpt_limit) begin
                    rpt_pending <= 1'b1;
                    rpt_cnt     <= '0;
                    rpt_first   <= 1'b0;
                end else begin
                    rpt_cnt <= rpt_cnt + 32'd1;
                end
            end

            if (bat_reset) begin
                key_down    <= '0;
                rpt_valid   <= 1'b0;
                rpt_pending <= 1'b0;
            end
            if (do_press) begin
                key_down[hit_idx] <= 1'b1;
                rpt_valid         <= 1'b1;
                rpt_idx           <= hit_idx;
                rpt_first         <= 1'b1;
                rpt_cnt           <= '0;
                rpt_pending       <= 1'b0;
            end
            if (do_release) begin
                key_down[hit_idx] <= 1'b0;
                if (rpt_valid && rpt_idx == hit_idx) begin
                    rpt_valid   <= 1'b0;
                    rpt_pending <= 1'b0;
                end
            end

            if (par_push && fifo_full && !pop) overflow <= 1'b1;
            else if (clear_overflow)           overflow <= 1'b0;
        end
    end

    sync_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (par_push || rep_push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid   = !fifo_empty;
    assign evt_idx     = head[IDX_W-1:0];
    assign evt_release = head[IDX_W];
    assign evt_repeat  = head[IDX_W+1];

endmodule

// File: tb/tb_ps2_key_event_queue.sv
module tb_ps2_key_event_queue;

    localparam int unsigned NK    = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned DLY   = 20;
    localparam int unsigned RATE  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       evt_ready = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_idx;
    logic       evt_release;
    logic       evt_repeat;
    logic [3:0] key_down;
    logic [1:0] fifo_count;
    logic       overflow;

    ps2_key_event_queue #(
        .NUM_KEYS     (NK),
        .DEPTH        (DEPTH),
        .REPEAT_EN    (1),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .evt_ready      (evt_ready),
        .evt_valid      (evt_valid),
        .evt_idx        (evt_idx),
        .evt_release    (evt_release),
        .evt_repeat     (evt_repeat),
        .key_down       (key_down),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: key table lookup, event list, absolute-time repeat schedule.
    typedef struct {
        int unsigned idx;
        bit          rel;
        bit          rep;
    } evt_t;

    int unsigned table_codes [NK] = '{'h05A, 'h029, 'h175, 'h172};
    evt_t        mq [$];
    bit          m_keys [NK];
    bit          m_ext = 0;
    bit          m_brk = 0;
    int          m_target = -1;
    bit          m_pending = 0;
    longint      m_next_raise = 0;
    bit          m_ovf = 0;
    longint      cyc = 0;

    int passes = 0;
    int fails  = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        int   hit;
        int   act;      // 0 none, 1 bat, 2 press, 3 release
        bit   brk_ev;
        bit   attempt;
        evt_t pe;
        evt_t re;
        int unsigned code;
        if (rst) begin
            mq.delete();
            foreach (m_keys[i]) m_keys[i] = 0;
            m_ext = 0; m_brk = 0; m_target = -1; m_pending = 0; m_ovf = 0;
            cyc++;
            return;
        end
        act = 0; hit = -1; brk_ev = 0; code = 0;
        if (byte_valid) begin
            if (!m_ext && !m_brk && byte_in == 8'hE0) m_ext = 1;
            else if (!m_brk && byte_in == 8'hF0) m_brk = 1;
            else if (!m_ext && !m_brk && byte_in == 8'hAA) act = 1;
            else begin
                code   = (m_ext ? 256 : 0) + int'(byte_in);
                brk_ev = m_brk;
                m_ext  = 0;
                m_brk  = 0;
                for (int i = NK - 1; i >= 0; i--)
                    if (table_codes[i] == code) hit = i;
                if (hit >= 0 && !brk_ev && !m_keys[hit]) act = 2;
                if (hit >= 0 &&  brk_ev &&  m_keys[hit]) act = 3;
            end
        end
        attempt = m_pending && !(act == 2 || act == 3);
        if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
        if (act == 2 || act == 3) begin
            pe.idx = hit; pe.rel = (act == 3); pe.rep = 0;
            if (mq.size() < DEPTH) mq.push_back(pe);
            else m_ovf = 1;
            if (mq.size() <= DEPTH && clear_overflow && !(mq.size() == DEPTH && mq[DEPTH-1] != pe)) begin
            end
        end
        if (attempt) begin
            re.idx = m_target; re.rel = 0; re.rep = 1;
            if (mq.size() < DEPTH) mq.push_back(re);
        end
        if (attempt) m_pending = 0;
        if (m_target >= 0 && cyc == m_next_raise) begin
            m_pending = 1;
            m_next_raise = cyc + RATE;
        end
        if (act == 1) begin
            foreach (m_keys[i]) m_keys[i] = 0;
            m_target = -1; m_pending = 0;
        end else if (act == 2) begin
            m_keys[hit] = 1; m_target = hit; m_pending = 0; m_next_raise = cyc + DLY;
        end else if (act == 3) begin
            m_keys[hit] = 0;
            if (m_target == hit) begin m_target = -1; m_pending = 0; end
        end
        cyc++;
    endtask

    // Overflow is tracked separately so the set-beats-clear rule is explicit.
    bit drop_now;

    task automatic check_all();
        logic [3:0] mk;
        for (int i = 0; i < NK; i++) mk[i] = m_keys[i];
        check("evt_valid", evt_valid, mq.size() != 0);
        if (mq.size() > 0) begin
            check("evt_idx", evt_idx, mq[0].idx);
            check("evt_release", evt_release, mq[0].rel);
            check("evt_repeat", evt_repeat, mq[0].rep);
        end
        check("key_down", key_down, mk);
        check("fifo_count", fifo_count, mq.size());
        check("overflow", overflow, m_ovf);
    endtask

    task automatic tick();
        bit was_ovf;
        bit clr;
        @(posedge clk);
        was_ovf = m_ovf;
        clr     = clear_overflow && !rst;
        m_ovf   = 0;
        model_step();
        // m_ovf now holds "dropped this cycle"; combine with history.
        drop_now = m_ovf;
        if (!rst) m_ovf = drop_now ? 1'b1 : (clr ? 1'b0 : was_ovf);
        #1;
        check_all();
        rst            = 1'b0;
        byte_valid     = 1'b0;
        clear_overflow = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    longint rep_cyc [$];
    int     late_reps;

    initial begin
        foreach (m_keys[i]) m_keys[i] = 0;

        // Reset state
        rst = 1'b1;
        tick();
        check("reset_count", fifo_count, 2'd0);
        check("reset_valid", evt_valid, 1'b0);

        // Enter press then release
        send(8'h5A);
        check("enter_down", key_down, 4'b0001);
        check("enter_press_idx", evt_idx, 2'd0);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        send(8'hF0);
        send(8'h5A);
        check("enter_up", key_down, 4'b0000);
        check("enter_release", evt_release, 1'b1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        // Extended up arrow, then un-prefixed 75 (keypad 8) is unmapped
        send(8'hE0); send(8'h75);
        check("up_press_idx", evt_idx, 2'd2);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_release_idx", evt_idx, 2'd2);
        check("up_release_rel", evt_release, 1'b1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        send(8'h75);
        check("kp8_no_event", fifo_count, 2'd0);

        // Typematic make while already down is suppressed
        send(8'h29);
        send(8'h29);
        check("space_dup_count", fifo_count, 2'd1);
        evt_ready = 1'b1;
        send(8'hF0); send(8'h29);
        idle(2);

        // Auto-repeat while holding space, none after release
        send(8'h29);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (evt_valid && evt_repeat) rep_cyc.push_back(cyc);
        end
        check("repeat_seen", rep_cyc.size() >= 3, 1'b1);
        for (int i = 1; i < rep_cyc.size(); i++)
            check("repeat_gap", 32'(rep_cyc[i] - rep_cyc[i-1]), RATE);
        send(8'hF0); send(8'h29);
        late_reps = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (evt_valid && evt_repeat) late_reps++;
        end
        check("no_repeat_after_release", late_reps, 0);

        // Overflow on a full queue, then clear with push+pop in one cycle
        rst = 1'b1; tick();
        evt_ready = 1'b0;
        send(8'h5A); send(8'h29); send(8'hE0); send(8'h75);
        check("ovf_count", fifo_count, 2'd2);
        check("ovf_set", overflow, 1'b1);
        send(8'hE0);
        byte_in = 8'h72; byte_valid = 1'b1; evt_ready = 1'b1; clear_overflow = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("ovf_pushpop_count", fifo_count, 2'd2);
        check("ovf_cleared", overflow, 1'b0);

        // Mid-operation reset, then BAT clears key_down silently
        rst = 1'b1; tick();
        check("midrst_valid", evt_valid, 1'b0);
        check("midrst_keys", key_down, 4'b0000);
        check("midrst_count", fifo_count, 2'd0);
        send(8'h5A); send(8'h29);
        send(8'hAA);
        check("bat_keys", key_down, 4'b0000);
        check("bat_no_event", fifo_count, 2'd2);

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            bit busy;
            busy = ((i / 200) % 2) == 0;
            rst  = ($urandom_range(0, 799) == 0);
            evt_ready = ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            byte_valid = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    byte_in = 8'h5A;
                2:       byte_in = 8'h29;
                3:       byte_in = 8'h75;
                4:       byte_in = 8'h72;
                5, 6:    byte_in = 8'hE0;
                7, 8, 9: byte_in = 8'hF0;
                10:      byte_in = 8'hAA;
                default: byte_in = 8'($urandom_range(0, 255));
            endcase
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
